// File: rtl/board_gpio_pkg.sv
// Shared types and helpers for the board GPIO block.
// Optional PWM dimming of ON-mode LEDs is enabled by BOARD_GPIO_PWM_EN.
package board_gpio_pkg;

    typedef enum logic [1:0] {
        LED_OFF        = 2'd0,
        LED_ON         = 2'd1,
        LED_BLINK_SLOW = 2'd2,
        LED_BLINK_FAST = 2'd3
    } led_mode_t;

    localparam int DEB_CYCLES_DEF = 200000;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // A single-sample debounce still needs a 1-bit counter.
    function automatic int cnt_width(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/board_gpio_ctrl_debounce.sv
// One input channel: two-flop synchroniser, stability counter and
// debounced level with a single-cycle change strobe.
module gpio_debounce
    import board_gpio_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic chg
);

    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    assign chg = (s2 != q) && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            q   <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == q) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                q   <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_gpio_ctrl.sv
// Board GPIO: debounced switches with change events, LED mode driver.
// Define BOARD_GPIO_PWM_EN for duty-cycle dimming of lit LEDs.
module board_gpio_ctrl
    import board_gpio_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int NUM_LED    = 8,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int PRESC_W    = 24
) (
    input  logic                 sys0_clk,
    input  logic                 sys0_rst,
    input  logic [NUM_IN-1:0]    sw_in,
    output logic [NUM_IN-1:0]    sw_q,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [NUM_IN-1:0]    evt_state,
    output logic [NUM_IN-1:0]    evt_mask,
    output logic                 evt_ovf,
    input  logic [2*NUM_LED-1:0] led_mode,
    input  logic [7:0]           led_duty,
    output logic [NUM_LED-1:0]   led
);

    logic [NUM_IN-1:0]  chg;
    logic [NUM_IN-1:0]  mask;
    logic               ovf;
    logic               accept;
    logic [PRESC_W-1:0] presc;
    logic [NUM_LED-1:0] led_nxt;
    logic               on_lvl;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_deb
        gpio_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk(sys0_clk),
            .rst(sys0_rst),
            .din(sw_in[gi]),
            .q  (sw_q[gi]),
            .chg(chg[gi])
        );
    end

    assign evt_valid = |mask;
    assign evt_state = sw_q;
    assign evt_mask  = mask;
    assign evt_ovf   = ovf;
    assign accept    = evt_valid & evt_ready;

    // Changes landing on an accept cycle start the next event.
    always_ff @(posedge sys0_clk) begin
        if (sys0_rst) begin
            mask <= '0;
            ovf  <= 1'b0;
        end else begin
            mask <= (accept ? '0 : mask) | chg;
            if (|(chg & mask) && !accept) begin
                ovf <= 1'b1;
            end else if (accept) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys0_clk) begin
        if (sys0_rst) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

`ifdef BOARD_GPIO_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge sys0_clk) begin
        if (sys0_rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    assign on_lvl = (pwm_cnt < led_duty);
`else
    logic unused_duty;

    assign unused_duty = ^led_duty;
    assign on_lvl      = 1'b1;
`endif

    always_comb begin
        led_nxt = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            unique case (led_mode_t'(led_mode[2*i +: 2]))
                LED_OFF:        led_nxt[i] = 1'b0;
                LED_ON:         led_nxt[i] = on_lvl;
                LED_BLINK_SLOW: led_nxt[i] = presc[PRESC_W-1] & on_lvl;
                LED_BLINK_FAST: led_nxt[i] = presc[PRESC_W-3] & on_lvl;
            endcase
        end
    end

    always_ff @(posedge sys0_clk) begin
        if (sys0_rst) begin
            led <= '0;
        end else begin
            led <= led_nxt;
        end
    end

endmodule

// File: tb/tb_board_gpio_ctrl.sv
// Randomised self-checking bench for board_gpio_ctrl against a
// cycle-level behavioural model (DEB_CYCLES=4, PRESC_W=6).
module tb_board_gpio_ctrl;

    localparam int NI  = 4;
    localparam int NL  = 8;
    localparam int DEB = 4;
    localparam int PW  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NI-1:0] sw_in = '0;
    logic [NI-1:0] sw_q;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [NI-1:0] evt_state;
    logic [NI-1:0] evt_mask;
    logic          evt_ovf;
    logic [15:0]   led_mode = '0;
    logic [7:0]    led_duty = '0;
    logic [NL-1:0] led;

    int checks   = 0;
    int failures = 0;

    board_gpio_ctrl #(
        .NUM_IN    (NI),
        .NUM_LED   (NL),
        .DEB_CYCLES(DEB),
        .PRESC_W   (PW)
    ) dut (
        .sys0_clk (clk),
        .sys0_rst (rst),
        .sw_in    (sw_in),
        .sw_q     (sw_q),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_state(evt_state),
        .evt_mask (evt_mask),
        .evt_ovf  (evt_ovf),
        .led_mode (led_mode),
        .led_duty (led_duty),
        .led      (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NI-1:0] hist[$];
    int            run[NI];
    logic [NI-1:0] m_q;
    logic [NI-1:0] m_mask;
    logic          m_ovf;
    logic [NL-1:0] m_led;
    int            n;
    bit            m_en = 0;

    function automatic logic [NL-1:0] led_exp(input logic [15:0] md,
                                              input int cyc,
                                              input logic [7:0] duty);
        logic [NL-1:0] r;
        logic          slow;
        logic          fast;
        logic          on;
        slow = ((cyc % (1 << PW)) >= (1 << (PW - 1)));
        fast = (((cyc % (1 << PW)) / (1 << (PW - 3))) % 2) == 1;
`ifdef BOARD_GPIO_PWM_EN
        on = (cyc % 256) < int'(duty);
`else
        on = 1'b1;
`endif
        for (int i = 0; i < NL; i++) begin
            case (md[2*i +: 2])
                2'd0: r[i] = 1'b0;
                2'd1: r[i] = on;
                2'd2: r[i] = slow & on;
                default: r[i] = fast & on;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [NI-1:0] seen;
        logic [NI-1:0] chg;
        logic          acc;
        if (rst) begin
            hist = '{4'b0, 4'b0};
            for (int i = 0; i < NI; i++) run[i] = 0;
            m_q = '0; m_mask = '0; m_ovf = 1'b0; m_led = '0;
            n = 0;
            m_en = 1;
        end else if (m_en) begin
            seen = hist.pop_front();
            hist.push_back(sw_in);
            chg = '0;
            for (int i = 0; i < NI; i++) begin
                if (seen[i] != m_q[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        chg[i] = 1'b1;
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            acc = (m_mask != 0) && evt_ready;
            if (((chg & m_mask) != 0) && !acc) m_ovf = 1'b1;
            else if (acc) m_ovf = 1'b0;
            m_mask = (acc ? '0 : m_mask) | chg;
            m_q = m_q ^ chg;
            m_led = led_exp(led_mode, n, led_duty);
            n++;
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            chk("sw_q", sw_q, m_q);
            chk("evt_state", evt_state, m_q);
            chk("evt_mask", evt_mask, m_mask);
            chk("evt_valid", evt_valid, m_mask != 0);
            chk("evt_ovf", evt_ovf, m_ovf);
            chk("led", led, m_led);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        int t0[$];
        int t1[$];
        logic p0;
        logic p1;
        int hi;

        tick(3);
        rst = 1'b0;
        tick(20);
        at_neg();
        chk("idle_sw_q", sw_q, 4'b0000);
        chk("idle_valid", evt_valid, 1'b0);
        chk("idle_led", led, 8'h00);

`ifndef BOARD_GPIO_PWM_EN
        tick(1);
        led_mode = 16'h5555;
        tick(1);
        at_neg();
        chk("all_on", led, 8'hFF);
`endif

        // Clean edge on channel 0: visible on the 6th edge.
        tick(1);
        sw_in[0] = 1'b1;
        tick(5);
        at_neg();
        chk("deb_early", sw_q[0], 1'b0);
        tick(1);
        at_neg();
        chk("deb_on_time", sw_q[0], 1'b1);
        chk("evt_mask_ch0", evt_mask, 4'b0001);
        chk("evt_state_ch0", evt_state, 4'b0001);
        tick(1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        at_neg();
        chk("accept_clears", evt_valid, 1'b0);

        // Short glitch on channel 1.
        sw_in[1] = 1'b1;
        tick(3);
        sw_in[1] = 1'b0;
        tick(10);
        at_neg();
        chk("glitch_sw_q", sw_q, 4'b0001);
        chk("glitch_mask", evt_mask, 4'b0000);

        // Channel 2 changes twice without accept.
        tick(1);
        sw_in[2] = 1'b1;
        tick(10);
        sw_in[2] = 1'b0;
        tick(10);
        at_neg();
        chk("ovf_mask", evt_mask, 4'b0100);
        chk("ovf_set", evt_ovf, 1'b1);
        tick(1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        at_neg();
        chk("ovf_acc_mask", evt_mask, 4'b0000);
        chk("ovf_acc_clr", evt_ovf, 1'b0);

        // Channel 3 completes on the same edge that accepts channel 0.
        tick(1);
        sw_in[0] = 1'b0;
        tick(2);
        sw_in[3] = 1'b1;
        tick(5);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        at_neg();
        chk("same_cyc_mask", evt_mask, 4'b1000);
        chk("same_cyc_valid", evt_valid, 1'b1);
        tick(1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;

        // Blink rates.
        led_mode = 16'h000E;
`ifdef BOARD_GPIO_PWM_EN
        led_duty = 8'd255;
`endif
        tick(1);
        at_neg();
        p0 = led[0];
        p1 = led[1];
        for (int c = 0; c < 200; c++) begin
            at_neg();
            if (led[0] != p0) t0.push_back(c);
            if (led[1] != p1) t1.push_back(c);
            p0 = led[0];
            p1 = led[1];
        end
        chk("slow_period", (t0.size() >= 3) ? t0[2] - t0[1] : 0, 32);
        chk("fast_period", (t1.size() >= 3) ? t1[2] - t1[1] : 0, 8);

`ifdef BOARD_GPIO_PWM_EN
        tick(1);
        led_mode = 16'h0001;
        led_duty = 8'd64;
        tick(2);
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            at_neg();
            if (led[0]) hi++;
        end
        chk("pwm_duty64", hi, 64);
`endif

        // Randomised traffic.
        tick(1);
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(7) == 0) sw_in[$urandom_range(NI-1)] ^= 1'b1;
            evt_ready = ($urandom_range(3) == 0);
            if ($urandom_range(63) == 0) led_mode = 16'($urandom);
            if ($urandom_range(63) == 0) led_duty = 8'($urandom);
            tick(1);
        end
        evt_ready = 1'b0;

        // Reset with an event pending and a debounce in progress.
        sw_in[1] = ~sw_in[1];
        tick(8);
        sw_in[2] = ~sw_in[2];
        tick(3);
        rst = 1'b1;
        tick(1);
        at_neg();
        chk("rst_sw_q", sw_q, 4'b0000);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_mask", evt_mask, 4'b0000);
        chk("rst_led", led, 8'h00);
        tick(1);
        rst = 1'b0;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
